mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the single Memory port between instruction fetch (port F) and load/store (port D).
// - Sits between the Fetcher, the CPU data path and the Memory instance. Issues one access at a time.
// - Data has priority; a starvation counter guarantees fetch progress.
// - Rejects misaligned data accesses without touching memory.
// PARAMETERS
// - ADDR_W      32  address width (matches addr_t)
// - DATA_W      32  data width (matches op_t)
// - MEM_LAT     1   cycles mem_addr is held before mem_rdata is sampled; legal 1..4
// - STARVE_MAX  4   max consecutive D grants while f_req is pending; legal 1..15
// PORTS
// - clk        in   1       clock, all state on posedge
// - rst        in   1       synchronous, active-high reset
// - f_req      in   1       fetch read request; held with f_addr until f_gnt
// - f_addr     in   ADDR_W  fetch address
// - f_gnt      out  1       1-cycle pulse: F request issued to memory this cycle
// - f_rvalid   out  1       1-cycle pulse: f_rdata valid
// - f_rdata    out  DATA_W  fetch read data; holds last value
// - d_req      in   1       data request; held with d_we/d_addr/d_wdata until d_gnt or d_err
// - d_we       in   1       1 = write, 0 = read
// - d_addr     in   ADDR_W  data address; must be word aligned
// - d_wdata    in   DATA_W  store data
// - d_gnt      out  1       1-cycle pulse: D request issued to memory
// - d_rvalid   out  1       1-cycle pulse: d_rdata valid (reads only)
// - d_rdata    out  DATA_W  load data; holds last value
// - d_err      out  1       1-cycle pulse: misaligned D request dropped
// - mem_addr   out  ADDR_W  to Memory.addr
// - mem_we     out  1       to Memory.enable_write
// - mem_wdata  out  DATA_W  to Memory.write_data
// - mem_rdata  in   DATA_W  from Memory.read_out
// - busy       out  1       1 while a read is outstanding
// BEHAVIOUR
// - Reset: state ARB_IDLE, streak = 0, lat_cnt = 0. All outputs are 0, including both rdata registers.
// - Arbitration happens only in ARB_IDLE.
//   - Winner is D if d_req and (!f_req or streak < STARVE_MAX); otherwise F if f_req.
// - A misaligned D request wins arbitration normally.
//   - Response: d_err = 1 that cycle, no d_gnt, mem_we = 0, no state change, streak unchanged.
//   - Misaligned means d_addr[1:0] != 0.
// - Grant cycle T (combinational):
//   - gnt pulses; mem_addr = winner addr.
//   - mem_we = d_we for D, 0 for F. mem_wdata = d_wdata for D writes, otherwise 0.
// - Write: completes in cycle T. State stays ARB_IDLE, so back-to-back writes run every cycle. No rvalid.
// - Read, states ARB_IDLE -> ARB_READ:
//   - At the T edge: latch addr and port sel, lat_cnt = MEM_LAT-1.
//   - ARB_READ holds mem_addr and decrements lat_cnt each cycle.
//   - mem_rdata is sampled into the selected rdata register on the edge where lat_cnt == 0 (MEM_LAT=1: at the T edge, ARB_READ skipped).
//   - rvalid pulses in cycle T+MEM_LAT. State is ARB_IDLE in that cycle, so a new grant may coincide with rvalid.
// - busy = (state == ARB_READ). In ARB_READ: no grants, mem_we = 0, requests wait.
// - streak:
//   - +1 (saturating) on each D grant while f_req = 1.
//   - Cleared on F grant, or on any cycle with f_req = 0.
// - Simultaneous f_req/d_req when streak == STARVE_MAX: F wins, streak -> 0.
// - Reset mid-read: transaction is abandoned. No rvalid, rdata registers -> 0.
// - Requests dropped before gnt are legal; no state is kept for them.
// STRUCTURE
// - Package MemArbType:
//   - arb_state_t {ARB_IDLE, ARB_READ}
//   - port_sel_t {SEL_FETCH, SEL_DATA}
//   - MEM_LAT_MAX = 4
// - Reuse Types::addr_t and Types::op_t.
// - Single module, no sub-module.
//   - One always_ff for state, streak, lat_cnt, latched addr/sel and rdata.
//   - One always_comb for grant and mux.
// TESTING
// - F-only read, MEM_LAT=1, f_addr=0x10, mem word 0x2402_0005.
//   -> f_gnt at T, f_rvalid at T+1, f_rdata = 0x2402_0005.
// - Both request at T: d_we=1, d_addr=0x20, d_wdata=0xDEAD_BEEF.
//   -> d_gnt and mem_we at T, f_gnt at T+1, memory[0x20] = 0xDEAD_BEEF.
// - STARVE_MAX=2, f_req held, D issues 4 back-to-back writes.
//   -> grants D, D, F, D, D; the F grant falls in the 3rd arbitration cycle.
// - d_addr=0x22, d_req=1 -> d_err pulse, mem_we = 0, no d_gnt, streak unchanged.
// - MEM_LAT=3, D read at T.
//   -> busy in T+1..T+2, mem_addr stable T..T+2, d_rvalid at T+3.
//   - f_req raised at T+1 is granted at T+3.
// - rst asserted at T+1 of a MEM_LAT=3 read.
//   -> no d_rvalid, all outputs 0 at T+2, clean F read succeeds afterwards.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared word types plus the state and port-select enums used by the memory port arbiter.
package Types;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] op_t;
endpackage

package MemArbType;
    typedef enum logic {ARB_IDLE, ARB_READ} arb_state_t;
    typedef enum logic {SEL_FETCH, SEL_DATA} port_sel_t;
    localparam int unsigned MEM_LAT_MAX = 4;
endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (F) and load/store (D): data priority with a
// starvation bound for fetch, one access at a time, misaligned data accesses rejected.
module mem_port_arbiter
    import MemArbType::*;
#(
    parameter int unsigned ADDR_W     = $bits(Types::addr_t),
    parameter int unsigned DATA_W     = $bits(Types::op_t),
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned LAT_W      = $clog2(MEM_LAT_MAX);
    localparam logic [3:0]  STREAK_MAX = 4'(STARVE_MAX);

    arb_state_t        state;
    port_sel_t         rd_sel;
    logic [ADDR_W-1:0] rd_addr;
    logic [LAT_W-1:0]  lat_cnt;
    logic [3:0]        streak;

    logic      d_win;
    logic      f_win;
    logic      misaligned;
    logic      rd_start;
    logic      capture;
    port_sel_t new_sel;
    port_sel_t cap_sel;

    always_comb begin
        d_win      = 1'b0;
        f_win      = 1'b0;
        misaligned = (d_addr[1:0] != 2'b00);
        busy       = (state == ARB_READ);
        if (state == ARB_IDLE) begin
            d_win = d_req && (!f_req || (streak < STREAK_MAX));
            f_win = f_req && !d_win;
        end
        d_gnt     = d_win && !misaligned;
        d_err     = d_win && misaligned;
        f_gnt     = f_win;
        mem_we    = d_gnt && d_we;
        mem_wdata = mem_we ? d_wdata : '0;
        if (busy)
            mem_addr = rd_addr;
        else if (d_gnt)
            mem_addr = d_addr;
        else if (f_gnt)
            mem_addr = f_addr;
        else
            mem_addr = '0;
        rd_start = f_gnt || (d_gnt && !d_we);
        new_sel  = f_gnt ? SEL_FETCH : SEL_DATA;
        // With MEM_LAT == 1 the read data is taken on the grant edge and ARB_READ is never entered.
        capture  = (busy && (lat_cnt == LAT_W'(1))) ||
                   (!busy && rd_start && (MEM_LAT == 1));
        cap_sel  = busy ? rd_sel : new_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            rd_sel   <= SEL_FETCH;
            rd_addr  <= '0;
            lat_cnt  <= '0;
            streak   <= '0;
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            f_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            if (capture) begin
                if (cap_sel == SEL_FETCH) begin
                    f_rdata  <= mem_rdata;
                    f_rvalid <= 1'b1;
                end else begin
                    d_rdata  <= mem_rdata;
                    d_rvalid <= 1'b1;
                end
            end

            if (!f_req || f_gnt)
                streak <= '0;
            else if (d_gnt && (streak < STREAK_MAX))
                streak <= streak + 4'd1;

            case (state)
                ARB_IDLE: begin
                    if (rd_start) begin
                        rd_addr <= mem_addr;
                        rd_sel  <= new_sel;
                        lat_cnt <= LAT_W'(MEM_LAT - 1);
                        if (MEM_LAT > 1)
                            state <= ARB_READ;
                    end
                end
                ARB_READ: begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                    if (lat_cnt == LAT_W'(1))
                        state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiter instances (MEM_LAT=1/STARVE_MAX=2 and MEM_LAT=3/STARVE_MAX=4) checked every cycle
// against a transaction-level model, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst       [2];
    logic        f_req     [2];
    logic [31:0] f_addr    [2];
    logic        f_gnt     [2];
    logic        f_rvalid  [2];
    logic [31:0] f_rdata   [2];
    logic        d_req     [2];
    logic        d_we      [2];
    logic [31:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic        d_gnt     [2];
    logic        d_rvalid  [2];
    logic [31:0] d_rdata   [2];
    logic        d_err     [2];
    logic [31:0] mem_addr  [2];
    logic        mem_we    [2];
    logic [31:0] mem_wdata [2];
    logic        busy      [2];

    int checks = 0;
    int errors = 0;

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int smax(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic logic [31:0] init_word(input int i, input int k);
        if (i == 0 && k == 4) return 32'h2402_0005;
        if (i == 1 && k == 4) return 32'hCAFE_F00D;
        if (i == 1 && k == 5) return 32'h1357_9BDF;
        return 32'hA5A5_0000 ^ (i << 12) ^ (k * 32'h0101);
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %h expected %h at %0t", nm, i, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        logic [31:0] emem [16];
        logic        filled = 1'b0;
        logic [2:0]  age;
        logic        rd_now;
        logic [31:0] rdata_g;

        // Memory returns the stored word only once the address has been held MEM_LAT cycles.
        always_comb begin
            rd_now  = f_gnt[g] | (d_gnt[g] & ~mem_we[g]);
            if ((rd_now || busy[g]) && ((rd_now ? 3'd0 : age) == 3'(lat(g) - 1)))
                rdata_g = emem[mem_addr[g][5:2]];
            else
                rdata_g = ~emem[mem_addr[g][5:2]];
        end

        always @(posedge clk) begin
            if (!filled) begin
                for (int k = 0; k < 16; k++) emem[k] <= init_word(g, k);
                filled <= 1'b1;
            end else if (mem_we[g]) begin
                emem[mem_addr[g][5:2]] <= mem_wdata[g];
            end
            if (rst[g])         age <= 3'd0;
            else if (rd_now)    age <= 3'd1;
            else if (busy[g])   age <= age + 3'd1;
        end

        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32),
            .MEM_LAT(g == 0 ? 1 : 3), .STARVE_MAX(g == 0 ? 2 : 4)
        ) u_dut (
            .clk(clk), .rst(rst[g]),
            .f_req(f_req[g]), .f_addr(f_addr[g]), .f_gnt(f_gnt[g]),
            .f_rvalid(f_rvalid[g]), .f_rdata(f_rdata[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]), .d_err(d_err[g]),
            .mem_addr(mem_addr[g]), .mem_we(mem_we[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(rdata_g), .busy(busy[g])
        );
    end

    // Transaction-level reference: one outstanding read with a completion cycle, a streak count,
    // and a shadow memory holding what every accepted write stored.
    int          cyc = 0;
    bit          m_init = 1'b0;
    int          streak_m [2];
    bit          pend     [2];
    int          resp_cyc [2];
    bit          rsel_d   [2];
    logic [31:0] raddr    [2];
    logic [31:0] rval     [2];
    logic [31:0] ef_rd    [2];
    logic [31:0] ed_rd    [2];
    logic [31:0] mm       [2][16];

    always @(negedge clk) begin
        bit e_fv, e_dv, busy_e, dwin, fwin, mis, e_dg, e_de, e_we;
        logic [31:0] e_ma, e_wd;
        if (!m_init) begin
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < 16; k++) mm[i][k] = init_word(i, k);
            m_init = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                streak_m[i] = 0;
                pend[i]     = 1'b0;
                ef_rd[i]    = '0;
                ed_rd[i]    = '0;
            end else begin
                e_fv = 1'b0;
                e_dv = 1'b0;
                if (pend[i] && cyc == resp_cyc[i]) begin
                    pend[i] = 1'b0;
                    if (rsel_d[i]) begin e_dv = 1'b1; ed_rd[i] = rval[i]; end
                    else           begin e_fv = 1'b1; ef_rd[i] = rval[i]; end
                end
                busy_e = pend[i];
                dwin   = !busy_e && d_req[i] && (!f_req[i] || streak_m[i] < smax(i));
                fwin   = !busy_e && f_req[i] && !dwin;
                mis    = (d_addr[i][1:0] != 2'b00);
                e_dg   = dwin && !mis;
                e_de   = dwin && mis;
                e_we   = e_dg && d_we[i];
                e_wd   = e_we ? d_wdata[i] : 32'h0;
                e_ma   = busy_e ? raddr[i] : e_dg ? d_addr[i] : fwin ? f_addr[i] : 32'h0;

                chk("f_gnt",     i, 32'(f_gnt[i]),    32'(fwin));
                chk("d_gnt",     i, 32'(d_gnt[i]),    32'(e_dg));
                chk("d_err",     i, 32'(d_err[i]),    32'(e_de));
                chk("busy",      i, 32'(busy[i]),     32'(busy_e));
                chk("mem_we",    i, 32'(mem_we[i]),   32'(e_we));
                chk("mem_wdata", i, mem_wdata[i],     e_wd);
                chk("mem_addr",  i, mem_addr[i],      e_ma);
                chk("f_rvalid",  i, 32'(f_rvalid[i]), 32'(e_fv));
                chk("d_rvalid",  i, 32'(d_rvalid[i]), 32'(e_dv));
                chk("f_rdata",   i, f_rdata[i],       ef_rd[i]);
                chk("d_rdata",   i, d_rdata[i],       ed_rd[i]);

                if (e_we) mm[i][d_addr[i][5:2]] = d_wdata[i];
                if (fwin || (e_dg && !d_we[i])) begin
                    pend[i]     = 1'b1;
                    resp_cyc[i] = cyc + lat(i);
                    rsel_d[i]   = !fwin;
                    raddr[i]    = fwin ? f_addr[i] : d_addr[i];
                    rval[i]     = mm[i][raddr[i][5:2]];
                end
                if (!f_req[i] || fwin)                     streak_m[i] = 0;
                else if (e_dg && streak_m[i] < smax(i))    streak_m[i] = streak_m[i] + 1;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          fg [2];
        bit          dg [2];
        logic [4:0]  pat;
        int          nd;
        bit          gotd;
        int          w;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; f_req[i] = 1'b0; f_addr[i] = '0;
            d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0;
        end
        repeat (3) step();
        rst[0] = 1'b0; rst[1] = 1'b0;
        step();

        // F-only read, MEM_LAT=1
        f_req[0] = 1'b1; f_addr[0] = 32'h10;
        @(negedge clk); chk("A_f_gnt", 0, 32'(f_gnt[0]), 32'd1);
        step(); f_req[0] = 1'b0;
        @(negedge clk);
        chk("A_f_rvalid", 0, 32'(f_rvalid[0]), 32'd1);
        chk("A_f_rdata",  0, f_rdata[0], 32'h2402_0005);
        step();

        // Simultaneous requests: D write first, F the cycle after
        f_req[0] = 1'b1; f_addr[0] = 32'h30;
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h20; d_wdata[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("B_d_gnt",    0, 32'(d_gnt[0]),  32'd1);
        chk("B_mem_we",   0, 32'(mem_we[0]), 32'd1);
        chk("B_f_gnt_T",  0, 32'(f_gnt[0]),  32'd0);
        chk("B_mem_addr", 0, mem_addr[0],    32'h20);
        step(); d_req[0] = 1'b0; d_we[0] = 1'b0;
        @(negedge clk); chk("B_f_gnt_T1", 0, 32'(f_gnt[0]), 32'd1);
        step(); f_req[0] = 1'b0;
        @(negedge clk); chk("B_mem20", 0, gen_dut[0].emem[8], 32'hDEAD_BEEF);
        step();

        // Starvation bound 2: four back-to-back writes against a held fetch
        f_req[0] = 1'b1; f_addr[0] = 32'h04;
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h00; d_wdata[0] = $urandom;
        nd = 0; pat = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            pat  = {pat[3:0], d_gnt[0]};
            gotd = d_gnt[0];
            chk("C_one_grant", 0, 32'(f_gnt[0] ^ d_gnt[0]), 32'd1);
            step();
            if (gotd) begin
                nd++;
                if (nd == 4) d_req[0] = 1'b0;
                else begin d_addr[0] = nd * 4; d_wdata[0] = $urandom; end
            end
            if (c == 4) begin f_req[0] = 1'b0; d_req[0] = 1'b0; end
        end
        chk("C_pattern", 0, 32'(pat), 32'b11011);
        step();

        // Misaligned request leaves the streak untouched: D, ERR, D, F
        f_req[0] = 1'b1; f_addr[0] = 32'h08;
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h00; d_wdata[0] = $urandom;
        @(negedge clk); chk("D_gnt1", 0, 32'(d_gnt[0]), 32'd1);
        step(); d_addr[0] = 32'h22;
        @(negedge clk);
        chk("D_err",      0, 32'(d_err[0]),  32'd1);
        chk("D_no_gnt",   0, 32'(d_gnt[0]),  32'd0);
        chk("D_no_we",    0, 32'(mem_we[0]), 32'd0);
        chk("D_no_f_gnt", 0, 32'(f_gnt[0]),  32'd0);
        step(); d_addr[0] = 32'h08;
        @(negedge clk); chk("D_gnt2", 0, 32'(d_gnt[0]), 32'd1);
        step(); d_addr[0] = 32'h0C;
        @(negedge clk);
        chk("D_f_gnt",  0, 32'(f_gnt[0]), 32'd1);
        chk("D_gnt3_0", 0, 32'(d_gnt[0]), 32'd0);
        step(); f_req[0] = 1'b0; d_req[0] = 1'b0; d_we[0] = 1'b0;
        step();

        // MEM_LAT=3 data read with a fetch arriving at T+1
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h14;
        @(negedge clk);
        chk("E_d_gnt", 1, 32'(d_gnt[1]), 32'd1);
        chk("E_addr0", 1, mem_addr[1], 32'h14);
        chk("E_busy0", 1, 32'(busy[1]), 32'd0);
        step(); d_req[1] = 1'b0; f_req[1] = 1'b1; f_addr[1] = 32'h18;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk("E_busy",  1, 32'(busy[1]), 32'd1);
            chk("E_addr",  1, mem_addr[1], 32'h14);
            chk("E_f_wait", 1, 32'(f_gnt[1]), 32'd0);
            step();
        end
        @(negedge clk);
        chk("E_d_rvalid", 1, 32'(d_rvalid[1]), 32'd1);
        chk("E_d_rdata",  1, d_rdata[1], 32'h1357_9BDF);
        chk("E_f_gnt",    1, 32'(f_gnt[1]), 32'd1);
        step(); f_req[1] = 1'b0;
        repeat (4) step();

        // Reset at T+1 of a MEM_LAT=3 read abandons it
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h14;
        @(negedge clk); chk("F_d_gnt", 1, 32'(d_gnt[1]), 32'd1);
        step(); d_req[1] = 1'b0; rst[1] = 1'b1;
        step(); rst[1] = 1'b0;
        @(negedge clk);
        chk("F_busy",     1, 32'(busy[1]),     32'd0);
        chk("F_d_rvalid", 1, 32'(d_rvalid[1]), 32'd0);
        chk("F_f_rvalid", 1, 32'(f_rvalid[1]), 32'd0);
        chk("F_d_rdata",  1, d_rdata[1],       32'd0);
        chk("F_f_rdata",  1, f_rdata[1],       32'd0);
        chk("F_mem_addr", 1, mem_addr[1],      32'd0);
        chk("F_gnts",     1, 32'({f_gnt[1], d_gnt[1], d_err[1], mem_we[1]}), 32'd0);
        step();
        @(negedge clk); chk("F_d_rvalid2", 1, 32'(d_rvalid[1]), 32'd0);
        step(); f_req[1] = 1'b1; f_addr[1] = 32'h10;
        @(negedge clk); chk("F_f_gnt", 1, 32'(f_gnt[1]), 32'd1);
        step(); f_req[1] = 1'b0;
        step(); step();
        @(negedge clk);
        chk("F_f_rvalid3", 1, 32'(f_rvalid[1]), 32'd1);
        chk("F_f_rdata3",  1, f_rdata[1], 32'hCAFE_F00D);
        step();

        // Randomised traffic on both instances
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                fg[i] = f_gnt[i];
                dg[i] = d_gnt[i] | d_err[i];
            end
            step();
            for (int i = 0; i < 2; i++) begin
                rst[i] = ($urandom_range(499) == 0);
                if (f_req[i] && !fg[i]) begin
                    if ($urandom_range(31) == 0) f_req[i] = 1'b0;
                end else begin
                    f_req[i]  = ($urandom_range(99) < 55);
                    w         = $urandom_range(15);
                    f_addr[i] = 32'(w) << 2;
                end
                if (d_req[i] && !dg[i]) begin
                    if ($urandom_range(31) == 0) d_req[i] = 1'b0;
                end else begin
                    d_req[i]   = ($urandom_range(99) < 60);
                    d_we[i]    = $urandom_range(1) == 1;
                    w          = $urandom_range(15);
                    d_addr[i]  = (32'(w) << 2) |
                                 (($urandom_range(7) == 0) ? 32'($urandom_range(3, 1)) : 32'd0);
                    d_wdata[i] = $urandom;
                end
                if (rst[i]) begin f_req[i] = 1'b0; d_req[i] = 1'b0; end
            end
        end
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; f_req[i] = 1'b0; d_req[i] = 1'b0;
        end
        repeat (8) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
